// File: rtl/updown_pkg.sv
// Shared definitions for the parametrised up/down counter: mode encodings.
package updown_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_DOWN   = 2'b00;
  localparam mode_t MODE_UP     = 2'b01;
  localparam mode_t MODE_BOUNCE = 2'b10;
  localparam mode_t MODE_HOLD   = 2'b11;

endpackage

// File: rtl/updown_step_unit.sv
// Combinational step arithmetic: computes the next count and boundary events
// for one step in the given direction.
module updown_step_unit #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo_lim,
  input  logic [WIDTH-1:0]  hi_lim,
  input  logic              dir_up,
  input  logic              sat,
  input  logic              bounce,
  output logic [WIDTH-1:0]  next_count,
  output logic              up_evt,
  output logic              down_evt
);

  logic [WIDTH:0] w_step_ext;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic [WIDTH:0] w_lo_plus;
  logic           w_step_nz;

  // One extra bit keeps the comparisons free of wrap-around.
  assign w_step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign w_sum      = {1'b0, count} + w_step_ext;
  assign w_diff     = {1'b0, count} - w_step_ext;
  assign w_lo_plus  = {1'b0, lo_lim} + w_step_ext;
  assign w_step_nz  = (step != '0);

  assign up_evt   = w_step_nz &&  dir_up && (w_sum > {1'b0, hi_lim});
  assign down_evt = w_step_nz && !dir_up && ({1'b0, count} < w_lo_plus);

  always_comb begin
    next_count = count;
    if (up_evt) begin
      next_count = (bounce || sat) ? hi_lim : lo_lim;
    end else if (down_evt) begin
      next_count = (bounce || sat) ? lo_lim : hi_lim;
    end else if (w_step_nz) begin
      next_count = dir_up ? w_sum[WIDTH-1:0] : w_diff[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/updown_ctr_param.sv
// Parametrised up/down/bounce counter with load, limits, wrap/saturate,
// terminal-count pulse and sticky boundary flags.
module updown_ctr_param
  import updown_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              en,
  input  mode_t             mode,
  input  logic              sat,
  input  logic              load,
  input  logic [WIDTH-1:0]  din,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo_lim,
  input  logic [WIDTH-1:0]  hi_lim,
  input  logic              flag_clr,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              tc,
  output logic              ovf,
  output logic              udf,
  output logic              lim_err
);

  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_tc;
  logic             r_ovf;
  logic             r_udf;
  logic             r_lim_err;

  logic             w_lim_bad;
  logic             w_dir_up;
  logic             w_bounce;
  logic             w_active;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_clamped;
  logic             w_up_evt;
  logic             w_down_evt;

  assign w_lim_bad = (lo_lim > hi_lim);
  assign w_bounce  = (mode == MODE_BOUNCE);
  assign w_dir_up  = w_bounce ? r_dir : mode[0];
  assign w_active  = en && (mode != MODE_HOLD);
  assign w_clamped = (din < lo_lim) ? lo_lim : ((din > hi_lim) ? hi_lim : din);

  updown_step_unit #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step (
    .count      (r_count),
    .step       (step),
    .lo_lim     (lo_lim),
    .hi_lim     (hi_lim),
    .dir_up     (w_dir_up),
    .sat        (sat),
    .bounce     (w_bounce),
    .next_count (w_next),
    .up_evt     (w_up_evt),
    .down_evt   (w_down_evt)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count   <= RESET_VAL;
      r_dir     <= 1'b1;
      r_tc      <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_lim_err <= 1'b0;
    end else begin
      r_lim_err <= w_lim_bad;
      r_tc      <= 1'b0;
      if (flag_clr) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end
      if (w_lim_bad) begin
        r_count <= r_count;
      end else if (load) begin
        r_count <= w_clamped;
      end else if (w_active) begin
        r_count <= w_next;
        r_tc    <= w_up_evt || w_down_evt;
        // A flag set on the same edge as flag_clr must win, so it comes last.
        if (w_up_evt)   r_ovf <= 1'b1;
        if (w_down_evt) r_udf <= 1'b1;
        if (!w_bounce) begin
          r_dir <= mode[0];
        end else if (w_up_evt) begin
          r_dir <= 1'b0;
        end else if (w_down_evt) begin
          r_dir <= 1'b1;
        end
      end
    end
  end

  assign count   = r_count;
  assign dir     = r_dir;
  assign tc      = r_tc;
  assign ovf     = r_ovf;
  assign udf     = r_udf;
  assign lim_err = r_lim_err;

endmodule

// File: tb/tb_updown_ctr_param.sv
// Directed bench for updown_ctr_param with hand-computed expected values.
module tb_updown_ctr_param;
  import updown_pkg::*;

  localparam int W  = 8;
  localparam int SW = 4;

  logic          clk;
  logic          clr_n;
  logic          en;
  mode_t         mode;
  logic          sat;
  logic          load;
  logic [W-1:0]  din;
  logic [SW-1:0] step;
  logic [W-1:0]  lo_lim;
  logic [W-1:0]  hi_lim;
  logic          flag_clr;
  logic [W-1:0]  count;
  logic          dir;
  logic          tc;
  logic          ovf;
  logic          udf;
  logic          lim_err;

  int n_compared;
  int n_mismatched;

  updown_ctr_param #(
    .WIDTH     (W),
    .STEP_W    (SW),
    .RESET_VAL (8'd0)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .en       (en),
    .mode     (mode),
    .sat      (sat),
    .load     (load),
    .din      (din),
    .step     (step),
    .lo_lim   (lo_lim),
    .hi_lim   (hi_lim),
    .flag_clr (flag_clr),
    .count    (count),
    .dir      (dir),
    .tc       (tc),
    .ovf      (ovf),
    .udf      (udf),
    .lim_err  (lim_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp_val);
    n_compared++;
    if (obs != exp_val) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_val);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_up_cnt[5]  = '{10, 13, 16, 19, 10};
  int exp_up_tc[5]   = '{1, 0, 0, 0, 1};
  int exp_bn_cnt[7]  = '{2, 4, 5, 3, 1, 0, 2};
  int exp_bn_tc[7]   = '{0, 0, 1, 0, 0, 1, 0};
  int exp_bn_dir[7]  = '{1, 1, 0, 0, 0, 1, 1};

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    clr_n    = 1'b0;
    en       = 1'b0;
    mode     = MODE_HOLD;
    sat      = 1'b0;
    load     = 1'b0;
    din      = '0;
    step     = '0;
    lo_lim   = 8'd0;
    hi_lim   = 8'd255;
    flag_clr = 1'b0;

    #12;
    check_eq("rst_count", count, 0);
    check_eq("rst_dir", dir, 1);
    check_eq("rst_tc", tc, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_udf", udf, 0);
    check_eq("rst_lim_err", lim_err, 0);
    clr_n = 1'b1;
    tick();

    // Up wrap
    lo_lim = 8'd10; hi_lim = 8'd20; step = 4'd3; din = 8'd18; load = 1'b1;
    tick();
    load = 1'b0;
    check_eq("upw_load", count, 18);
    mode = MODE_UP; sat = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("upw_cnt%0d", i), count, exp_up_cnt[i]);
      check_eq($sformatf("upw_tc%0d", i), tc, exp_up_tc[i]);
      if (i == 0) check_eq("upw_ovf", ovf, 1);
    end
    en = 1'b0; flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check_eq("upw_ovf_clr", ovf, 0);

    // Down saturate
    step = 4'd4; din = 8'd12; load = 1'b1;
    tick();
    load = 1'b0;
    check_eq("dns_load", count, 12);
    mode = MODE_DOWN; sat = 1'b1; en = 1'b1;
    tick();
    check_eq("dns_cnt0", count, 10);
    check_eq("dns_tc0", tc, 1);
    check_eq("dns_udf", udf, 1);
    check_eq("dns_dir", dir, 0);
    tick();
    check_eq("dns_cnt1", count, 10);
    check_eq("dns_tc1", tc, 1);
    en = 1'b0; flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check_eq("dns_udf_clr", udf, 0);
    check_eq("dns_tc_idle", tc, 0);

    // Bounce
    lo_lim = 8'd0; hi_lim = 8'd5; din = 8'd0; load = 1'b1;
    tick();
    load = 1'b0;
    en = 1'b1; mode = MODE_UP; step = 4'd0;
    tick();
    check_eq("bnc_start_cnt", count, 0);
    check_eq("bnc_start_dir", dir, 1);
    check_eq("bnc_step0_tc", tc, 0);
    step = 4'd2; mode = MODE_BOUNCE;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq($sformatf("bnc_cnt%0d", i), count, exp_bn_cnt[i]);
      check_eq($sformatf("bnc_tc%0d", i), tc, exp_bn_tc[i]);
      check_eq($sformatf("bnc_dir%0d", i), dir, exp_bn_dir[i]);
    end

    // Load priority and clamp
    mode = MODE_UP; step = 4'd1; lo_lim = 8'd0; hi_lim = 8'd20;
    din = 8'd200; load = 1'b1;
    tick();
    check_eq("ld_clamp", count, 20);
    check_eq("ld_tc", tc, 0);
    check_eq("ld_lim_err", lim_err, 0);
    lo_lim = 8'd30; din = 8'd5;
    tick();
    check_eq("lim_err_set", lim_err, 1);
    check_eq("lim_err_hold", count, 20);
    load = 1'b0; lo_lim = 8'd0;

    // Flag race
    en = 1'b0; flag_clr = 1'b1;
    tick();
    check_eq("race_pre_ovf", ovf, 0);
    check_eq("race_lim_ok", lim_err, 0);
    en = 1'b1; mode = MODE_UP; sat = 1'b1; step = 4'd1;
    tick();
    check_eq("race_cnt", count, 20);
    check_eq("race_tc", tc, 1);
    check_eq("race_ovf", ovf, 1);
    en = 1'b0;
    tick();
    check_eq("race_ovf_clr", ovf, 0);
    flag_clr = 1'b0;

    // Asynchronous reset mid-count
    hi_lim = 8'd255; din = 8'd37; load = 1'b1;
    tick();
    load = 1'b0;
    en = 1'b1; mode = MODE_DOWN; step = 4'd3;
    tick();
    check_eq("ar_pre_cnt", count, 34);
    en = 1'b0;
    tick();
    load = 1'b1; din = 8'd37;
    tick();
    load = 1'b0;
    check_eq("ar_loaded", count, 37);
    check_eq("ar_pre_dir", dir, 0);
    #2;
    clr_n = 1'b0;
    #1;
    check_eq("ar_count", count, 0);
    check_eq("ar_dir", dir, 1);
    check_eq("ar_tc", tc, 0);
    check_eq("ar_ovf", ovf, 0);
    check_eq("ar_udf", udf, 0);
    check_eq("ar_lim_err", lim_err, 0);
    #10;
    clr_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
